// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
//
// Time-multiplexed hex display driver for NUM_DIGITS common-anode digits.
// It generates its own scan timing. A prescaler (phase) divides clk into
// digit slots of SCAN_DIV cycles, and scan_idx walks the digits 0..N-1.
// Each digit can be enabled or disabled and can light its decimal point.
// Leading zeros can be blanked. Brightness is set by PWM inside each slot.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : synchronous, active-high reset
//   en         : 1 = scan and display; 0 = freeze scan and blank the display
//   value      : packed hex; digit i = value[4*(N-1-i) +: 4]
//                (digit 0 is the leftmost, most significant digit)
//   digit_en   : bit i = 1 enables digit i
//   dp         : bit i = 1 lights the decimal point of digit i
//   lz_blank   : 1 = blank leading zero digits (the last digit is never blanked)
//   brightness : 0 = dark ... all-ones = full on
//   seg[0:6]   : segments a..g, active low, seg[0] = a
//   dp_n       : decimal point, active low
//   anode      : active low; digit i drives anode[N-1-i]
//   scan_idx   : digit that currently owns the slot
//   frame_tick : 1-cycle pulse in the cycle after scan_idx wraps N-1 -> 0
//
// seg, dp_n and anode are registered. Each one shows the scan state and
// the inputs from the previous cycle. No handshake is involved: the outputs
// are a free-running level interface that is valid in every cycle after
// reset.
// ---------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 100000,
    parameter int BRIGHT_W   = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [4*NUM_DIGITS-1:0]       value,
    input  logic [NUM_DIGITS-1:0]         digit_en,
    input  logic [NUM_DIGITS-1:0]         dp,
    input  logic                          lz_blank,
    input  logic [BRIGHT_W-1:0]           brightness,
    output logic [0:6]                    seg,
    output logic                          dp_n,
    output logic [NUM_DIGITS-1:0]         anode,
    output logic [$clog2(NUM_DIGITS)-1:0] scan_idx,
    output logic                          frame_tick
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int PH_W  = $clog2(SCAN_DIV);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PH_W-1:0]  LAST_PH  = PH_W'(SCAN_DIV - 1);
    // Width of one brightness step in phase counts.
    localparam logic [31:0]      STEP     = 32'(SCAN_DIV >> BRIGHT_W);

    logic [PH_W-1:0] phase;

    // Values for the digit that owns the current slot.
    logic [3:0]            cur_nib;
    logic                  cur_den;
    logic                  cur_dp;
    logic                  zero_acc;
    logic                  zero_run;
    logic                  blanked;
    logic                  pwm_on;
    logic                  lit;
    logic [0:6]            next_seg;
    logic                  next_dp_n;
    logic [NUM_DIGITS-1:0] next_anode;

    function automatic logic [0:6] decode(input logic [3:0] nib);
        logic [0:6] s;
        case (nib)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // Select the active digit's nibble and flags. The same loop builds a
    // running "all nibbles so far are zero" flag. At the active digit k this
    // flag tells whether digits 0..k are all zero, which decides leading-zero
    // blanking. digit_en plays no part in that test.
    always_comb begin
        cur_nib  = 4'h0;
        cur_den  = 1'b0;
        cur_dp   = 1'b0;
        zero_run = 1'b0;
        zero_acc = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            zero_acc = zero_acc & (value[4*(NUM_DIGITS-1-i) +: 4] == 4'h0);
            if (scan_idx == IDX_W'(i)) begin
                cur_nib  = value[4*(NUM_DIGITS-1-i) +: 4];
                cur_den  = digit_en[i];
                cur_dp   = dp[i];
                zero_run = zero_acc;
            end
        end
    end

    // PWM: full brightness covers the whole slot. Any other level lights the
    // digit for the first brightness*STEP phases, so level 0 is always dark.
    always_comb begin
        if (brightness == {BRIGHT_W{1'b1}}) begin
            pwm_on = 1'b1;
        end else begin
            pwm_on = (32'(phase) < (32'(brightness) * STEP));
        end
    end

    assign blanked = lz_blank && (scan_idx != LAST_IDX) && zero_run;
    assign lit     = cur_den && !blanked && pwm_on;

    // At most one anode bit goes low, and only when the active digit is lit.
    always_comb begin
        next_anode = '1;
        next_seg   = 7'b1111111;
        next_dp_n  = 1'b1;
        if (lit) begin
            next_seg  = decode(cur_nib);
            next_dp_n = ~cur_dp;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (scan_idx == IDX_W'(i)) begin
                    next_anode[NUM_DIGITS-1-i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase      <= '0;
            scan_idx   <= '0;
            frame_tick <= 1'b0;
            seg        <= 7'b1111111;
            dp_n       <= 1'b1;
            anode      <= '1;
        end else if (en) begin
            // frame_tick is set on the same edge that wraps scan_idx to 0.
            frame_tick <= (phase == LAST_PH) && (scan_idx == LAST_IDX);
            if (phase == LAST_PH) begin
                phase    <= '0;
                scan_idx <= (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
            end else begin
                phase <= phase + 1'b1;
            end
            seg   <= next_seg;
            dp_n  <= next_dp_n;
            anode <= next_anode;
        end else begin
            // Frozen: keep the scan position, blank the display.
            frame_tick <= 1'b0;
            seg        <= 7'b1111111;
            dp_n       <= 1'b1;
            anode      <= '1;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_driver
//
// Bench for seg7_scan_driver with NUM_DIGITS=4, SCAN_DIV=8, BRIGHT_W=2.
// A driver issues one cycle of stimulus at a time. Before each clock edge it
// pushes the output expected after that edge into exp_q. A monitor pops one
// entry at every falling edge and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_seg7_scan_driver;

    localparam int N   = 4;
    localparam int DIV = 8;
    localparam int BW  = 2;
    localparam int W   = 15;  // {anode[3:0], seg[6:0], dp_n, frame_tick, idx[1:0]}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          en;
    logic [15:0]   value;
    logic [3:0]    digit_en;
    logic [3:0]    dp;
    logic          lz_blank;
    logic [BW-1:0] brightness;
    logic [0:6]    seg;
    logic          dp_n;
    logic [3:0]    anode;
    logic [1:0]    scan_idx;
    logic          frame_tick;

    seg7_scan_driver #(
        .NUM_DIGITS(N),
        .SCAN_DIV  (DIV),
        .BRIGHT_W  (BW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .value     (value),
        .digit_en  (digit_en),
        .dp        (dp),
        .lz_blank  (lz_blank),
        .brightness(brightness),
        .seg       (seg),
        .dp_n      (dp_n),
        .anode     (anode),
        .scan_idx  (scan_idx),
        .frame_tick(frame_tick)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // Segment patterns a..g (leftmost character is segment a).
    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Reference scan position. This is the state before the next clock edge.
    int m_ph  = 0;
    int m_idx = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Work out the output for the current inputs and model state, push it,
    // advance the model, then clock once. The task returns 1 time unit after
    // the rising edge.
    task automatic tick();
        logic [3:0] an;
        logic [6:0] sg;
        logic       dn;
        logic       ft;
        logic       blank;
        logic       pwm;
        logic [3:0] nib;
        int         k;
        an = 4'hF;
        sg = 7'h7F;
        dn = 1'b1;
        ft = 1'b0;
        if (rst) begin
            m_ph  = 0;
            m_idx = 0;
        end else if (en) begin
            k     = m_idx;
            nib   = 4'(value >> (4 * (3 - k)));
            blank = lz_blank && (k < 3) && ((value >> (4 * (3 - k))) == 16'h0);
            pwm   = (brightness == 2'd3) || (m_ph < int'(brightness) * 2);
            if (digit_en[k] && !blank && pwm) begin
                an = 4'hF & ~(4'b0001 << (3 - k));
                sg = seg_tab[nib];
                dn = ~dp[k];
            end
            ft = (m_ph == DIV - 1) && (m_idx == N - 1);
            if (m_ph == DIV - 1) begin
                m_ph  = 0;
                m_idx = (m_idx + 1) % N;
            end else begin
                m_ph++;
            end
        end
        exp_q.push_back({an, sg, dn, ft, 2'(m_idx)});
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    // Step until the model reaches the given slot and phase (bounded).
    task automatic run_until(input int idx, input int ph, input int limit);
        int n;
        n = 0;
        while (!(m_idx == idx && m_ph == ph) && n < limit) begin
            tick();
            n++;
        end
        check("run_until_reached", 32'(n < limit || (m_idx == idx && m_ph == ph)), 32'd1);
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("anode",      32'(anode),      32'(e[14:11]));
                check("seg",        32'(seg),        32'(e[10:4]));
                check("dp_n",       32'(dp_n),       32'(e[3]));
                check("frame_tick", 32'(frame_tick), 32'(e[2]));
                check("scan_idx",   32'(scan_idx),   32'(e[1:0]));
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int cnt;
        rst        = 1'b1;
        en         = 1'b1;
        value      = 16'h12AF;
        digit_en   = 4'b1111;
        dp         = 4'b0000;
        lz_blank   = 1'b0;
        brightness = 2'd3;

        // 1. reset, then a full-brightness scan of 12AF
        run(2);
        check("reset_anode", 32'(anode), 32'hF);
        check("reset_seg",   32'(seg),   32'h7F);
        check("reset_idx",   32'(scan_idx), 32'd0);
        rst = 1'b0;
        run(8);
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (frame_tick) cnt++;
        end
        check("frame_tick_per_32", 32'(cnt), 32'd1);

        // 2. leading-zero blanking
        value    = 16'h0005;
        lz_blank = 1'b1;
        run(32);
        value = 16'h0000;
        run(32);

        // 3. PWM brightness
        value    = 16'h12AF;
        lz_blank = 1'b0;
        brightness = 2'd1;
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (anode != 4'hF) cnt++;
        end
        check("pwm_b1_lit_cycles", 32'(cnt), 32'd8);
        brightness = 2'd0;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (anode != 4'hF) cnt++;
        end
        check("pwm_b0_lit_cycles", 32'(cnt), 32'd0);
        brightness = 2'd3;

        // 4. digit enables and decimal points
        dp = 4'b0100;
        run(32);
        digit_en = 4'b1011;
        run(32);
        digit_en = 4'b1111;
        dp       = 4'b0000;

        // 5. freeze mid-slot in slot 2
        run_until(2, 3, 64);
        en = 1'b0;
        run(5);
        check("freeze_idx",   32'(scan_idx), 32'd2);
        check("freeze_anode", 32'(anode),    32'hF);
        en = 1'b1;
        run(20);

        // 6. reset in slot 3, phase 5
        run_until(3, 5, 64);
        rst = 1'b1;
        tick();
        check("midreset_idx",   32'(scan_idx), 32'd0);
        check("midreset_anode", 32'(anode),    32'hF);
        check("midreset_seg",   32'(seg),      32'h7F);
        rst = 1'b0;
        tick();
        check("after_reset_anode", 32'(anode), 32'b0111);
        check("after_reset_seg",   32'(seg),   32'b1001111);
        run(12);

        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
